// File: rtl/pdp8_pkg.sv
// pdp8_pkg: shared PDP-8 types, opcode and state enums, auto-index range constants.
package pdp8_pkg;

    typedef logic [11:0] word_t;

    typedef enum logic {DATA_READ = 1'b0, INSTR_READ = 1'b1} read_type_t;

    typedef enum logic [2:0] {
        OP_AND, OP_TAD, OP_ISZ, OP_DCA, OP_JMS, OP_JMP, OP_IOT, OP_OPR
    } opcode_t;

    typedef enum logic [2:0] {IDLE, CALC, IRD, AINC, DONE} ea_state_t;

    localparam word_t AUTOINDEX_LO_DEF = 12'o0010;
    localparam word_t AUTOINDEX_HI_DEF = 12'o0017;

    function automatic logic is_mri(opcode_t op);
        return (op != OP_IOT) && (op != OP_OPR);
    endfunction

endpackage

// File: rtl/ea_sequencer.sv
// ea_sequencer: PDP-8 MRI effective-address sequencer with indirect fetch and auto-index write-back.
module ea_sequencer
    import pdp8_pkg::*;
#(
    parameter int          READ_LATENCY = 1,
    parameter logic [11:0] AUTOINDEX_LO = AUTOINDEX_LO_DEF,
    parameter logic [11:0] AUTOINDEX_HI = AUTOINDEX_HI_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] instr,
    input  logic [11:0] pc,
    output logic        busy,
    output logic        done,
    output logic [11:0] ea,
    output logic [11:0] mem_address,
    output logic [11:0] mem_write_data,
    output logic        mem_read_enable,
    output logic        mem_read_type,
    output logic        mem_write_enable,
    input  logic [11:0] mem_read_data
);

    ea_state_t   r_state;
    logic [11:0] r_instr;
    logic [4:0]  r_page;
    logic [11:0] r_ea;
    logic [11:0] r_addr;
    logic [11:0] r_wdata;
    logic [2:0]  r_wait;

    opcode_t     w_op;
    logic [11:0] w_base;
    logic        w_auto;
    logic        w_last;
    logic [11:0] w_inc;
    logic        w_unused;

    // only the page bits of pc ever matter
    assign w_unused = ^pc[6:0];
    assign w_op     = opcode_t'(r_instr[11:9]);
    assign w_base   = r_instr[7] ? {r_page, r_instr[6:0]} : {5'b0, r_instr[6:0]};
    assign w_auto   = (w_base >= AUTOINDEX_LO) && (w_base <= AUTOINDEX_HI);
    assign w_last   = r_wait == 3'(READ_LATENCY - 1);
    assign w_inc    = mem_read_data + 12'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_instr <= '0;
            r_page  <= '0;
            r_ea    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wait  <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_instr <= instr;
                    r_page  <= pc[11:7];
                    r_state <= CALC;
                end
                CALC: begin
                    r_wait <= '0;
                    if (!is_mri(w_op)) begin
                        r_ea    <= '0;
                        r_state <= DONE;
                    end else if (!r_instr[8]) begin
                        r_ea    <= w_base;
                        r_state <= DONE;
                    end else begin
                        r_addr  <= w_base;
                        r_state <= IRD;
                    end
                end
                IRD: begin
                    if (!w_last) begin
                        r_wait <= r_wait + 3'd1;
                    end else if (w_auto) begin
                        r_wdata <= w_inc;
                        r_ea    <= w_inc;
                        r_state <= AINC;
                    end else begin
                        r_ea    <= mem_read_data;
                        r_state <= DONE;
                    end
                end
                AINC:    r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy             = (r_state == CALC) || (r_state == IRD) || (r_state == AINC);
        done             = r_state == DONE;
        mem_read_enable  = r_state == IRD;
        mem_write_enable = r_state == AINC;
        mem_read_type    = DATA_READ;
        mem_address      = r_addr;
        mem_write_data   = r_wdata;
        ea               = r_ea;
    end

endmodule

// File: tb/tb_ea_sequencer.sv
// tb_ea_sequencer: scoreboard bench for ea_sequencer at READ_LATENCY 1 and 3 with simple memory models.
module tb_ea_sequencer;
    import pdp8_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0, start3 = 1'b0;
    logic [11:0] instr = '0, pc = '0;
    logic        sel = 1'b0;

    logic        busy1, done1, re1, rt1, we1, busy3, done3, re3, rt3, we3;
    logic [11:0] ea1, addr1, wd1, rd1, ea3, addr3, wd3, rd3;
    logic [11:0] mem1 [0:4095];
    logic [11:0] mem3 [0:4095];

    logic        busy_m, done_m, re_m, we_m;
    logic [11:0] ea_m, addr_m, wd_m;

    typedef struct {
        logic [11:0] ea;
        int          lat;
        int          rd;
        int          wr;
        logic [11:0] ad;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fails = 0;

    always #5 clk = ~clk;

    ea_sequencer #(.READ_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .instr(instr), .pc(pc),
        .busy(busy1), .done(done1), .ea(ea1), .mem_address(addr1),
        .mem_write_data(wd1), .mem_read_enable(re1), .mem_read_type(rt1),
        .mem_write_enable(we1), .mem_read_data(rd1)
    );

    ea_sequencer #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .instr(instr), .pc(pc),
        .busy(busy3), .done(done3), .ea(ea3), .mem_address(addr3),
        .mem_write_data(wd3), .mem_read_enable(re3), .mem_read_type(rt3),
        .mem_write_enable(we3), .mem_read_data(rd3)
    );

    assign rd1 = mem1[addr1];
    assign rd3 = mem3[addr3];
    always @(posedge clk) if (we1) mem1[addr1] <= wd1;
    always @(posedge clk) if (we3) mem3[addr3] <= wd3;

    assign busy_m = sel ? busy3 : busy1;
    assign done_m = sel ? done3 : done1;
    assign re_m   = sel ? re3 : re1;
    assign we_m   = sel ? we3 : we1;
    assign ea_m   = sel ? ea3 : ea1;
    assign addr_m = sel ? addr3 : addr1;
    assign wd_m   = sel ? wd3 : wd1;

    task automatic run_op(input logic use3, input logic [11:0] ins, input logic [11:0] p,
                          input logic [11:0] e_ea, input int e_lat, input int e_rd,
                          input int e_wr, input logic [11:0] e_ad, input logic hold);
        exp_t e;
        int cyc = 0, rd = 0, wr = 0;
        bit seen = 0;
        sb.push_back('{e_ea, e_lat, e_rd, e_wr, e_ad});
        sel = use3;
        @(negedge clk);
        instr = ins;
        pc = p;
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (!hold) begin start1 = 1'b0; start3 = 1'b0; end
            if (re_m) rd++;
            if (we_m) wr++;
            n_checks++;
            if (re_m && we_m) begin
                n_fails++;
                $display("FAIL strobe_overlap instr=%o cyc=%0d: re=%b we=%b, required not both high", ins, cyc, re_m, we_m);
            end
            if (re_m || we_m) begin
                n_checks++;
                if (addr_m !== e_ad) begin
                    n_fails++;
                    $display("FAIL mem_address instr=%o: got %o expected %o", ins, addr_m, e_ad);
                end
            end
            if (we_m) begin
                n_checks++;
                if (wd_m !== e_ea) begin
                    n_fails++;
                    $display("FAIL write_data instr=%o: got %o expected %o", ins, wd_m, e_ea);
                end
            end
            if (cyc == 1) begin
                n_checks++;
                if (busy_m !== 1'b1) begin
                    n_fails++;
                    $display("FAIL busy_after_start instr=%o: got %b expected 1", ins, busy_m);
                end
            end
            if (done_m === 1'b1) seen = 1;
        end
        start1 = 1'b0;
        start3 = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (!seen) begin
            n_fails++;
            $display("FAIL done_timeout instr=%o: no done within 30 cycles", ins);
        end else begin
            if (ea_m !== e.ea) begin
                n_fails++;
                $display("FAIL ea instr=%o pc=%o: got %o expected %o", ins, p, ea_m, e.ea);
            end
            n_checks++;
            if (cyc != e.lat) begin
                n_fails++;
                $display("FAIL latency instr=%o: got %0d expected %0d", ins, cyc, e.lat);
            end
            n_checks++;
            if (rd != e.rd || wr != e.wr) begin
                n_fails++;
                $display("FAIL strobe_count instr=%o: got rd=%0d wr=%0d expected rd=%0d wr=%0d", ins, rd, wr, e.rd, e.wr);
            end
            n_checks++;
            if (busy_m !== 1'b0) begin
                n_fails++;
                $display("FAIL busy_at_done instr=%o: got %b expected 0", ins, busy_m);
            end
        end
    endtask

    task automatic check_mem1(input logic [11:0] a, input logic [11:0] v);
        n_checks++;
        if (mem1[a] !== v) begin
            n_fails++;
            $display("FAIL mem1[%o]: got %o expected %o", a, mem1[a], v);
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if ({busy1, done1, re1, we1, rt1, ea1, addr1, wd1} !== 41'd0) begin
            n_fails++;
            $display("FAIL reset_state: busy=%b done=%b re=%b we=%b rt=%b ea=%o addr=%o wd=%o expected all 0",
                     busy1, done1, re1, we1, rt1, ea1, addr1, wd1);
        end
        n_checks++;
        if ({busy3, done3, re3, we3, ea3} !== 16'd0) begin
            n_fails++;
            $display("FAIL reset_state3: busy=%b done=%b re=%b we=%b ea=%o expected all 0", busy3, done3, re3, we3, ea3);
        end
    endtask

    task automatic test_direct;
        run_op(0, 12'o1055, 12'o0200, 12'o0055, 2, 0, 0, 12'o0000, 0);
        run_op(0, 12'o1255, 12'o4321, 12'o4255, 2, 0, 0, 12'o0000, 0);
        run_op(0, 12'o5255, 12'o7600, 12'o7655, 2, 0, 0, 12'o0000, 0);
    endtask

    task automatic test_indirect;
        run_op(0, 12'o1430, 12'o0200, 12'o3000, 3, 1, 0, 12'o0030, 0);
        check_mem1(12'o0030, 12'o3000);
        run_op(0, 12'o1610, 12'o0200, 12'o4444, 3, 1, 0, 12'o0210, 0);
        run_op(0, 12'o1420, 12'o0200, 12'o1234, 3, 1, 0, 12'o0020, 0);
        check_mem1(12'o0020, 12'o1234);
        run_op(0, 12'o1407, 12'o0200, 12'o2222, 3, 1, 0, 12'o0007, 0);
        check_mem1(12'o0007, 12'o2222);
    endtask

    task automatic test_autoindex;
        run_op(0, 12'o3410, 12'o0200, 12'o0000, 4, 1, 1, 12'o0010, 0);
        check_mem1(12'o0010, 12'o0000);
        run_op(0, 12'o3410, 12'o0200, 12'o0001, 4, 1, 1, 12'o0010, 0);
        check_mem1(12'o0010, 12'o0001);
        run_op(0, 12'o1610, 12'o0050, 12'o0002, 4, 1, 1, 12'o0010, 0);
        check_mem1(12'o0010, 12'o0002);
        run_op(0, 12'o1417, 12'o0200, 12'o0101, 4, 1, 1, 12'o0017, 0);
        check_mem1(12'o0017, 12'o0101);
    endtask

    task automatic test_non_mri;
        run_op(0, 12'o7200, 12'o0200, 12'o0000, 2, 0, 0, 12'o0000, 0);
        run_op(0, 12'o6410, 12'o0200, 12'o0000, 2, 0, 0, 12'o0000, 0);
    endtask

    task automatic test_start_held;
        int extra = 0;
        run_op(0, 12'o1055, 12'o0200, 12'o0055, 2, 0, 0, 12'o0000, 1);
        repeat (5) begin
            @(negedge clk);
            if (done1) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fails++;
            $display("FAIL start_held_single_done: got %0d extra done pulses expected 0", extra);
        end
        n_checks++;
        if (ea1 !== 12'o0055) begin
            n_fails++;
            $display("FAIL ea_held: got %o expected 0055", ea1);
        end
    endtask

    task automatic test_reset_mid;
        mem1[12'o0010] = 12'o5555;
        sel = 0;
        @(negedge clk);
        instr = 12'o3410;
        pc = 12'o0200;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (re1 !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_mid_in_ird: re got %b expected 1", re1);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy1, done1, re1, we1, ea1, addr1, wd1} !== 40'd0) begin
            n_fails++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b re=%b we=%b ea=%o addr=%o wd=%o expected all 0",
                     busy1, done1, re1, we1, ea1, addr1, wd1);
        end
        repeat (2) @(negedge clk);
        check_mem1(12'o0010, 12'o5555);
        rst_n = 1'b1;
    endtask

    task automatic test_latency3;
        run_op(1, 12'o1430, 12'o0200, 12'o3000, 5, 3, 0, 12'o0030, 0);
        run_op(1, 12'o3410, 12'o0200, 12'o0101, 6, 3, 1, 12'o0010, 0);
        n_checks++;
        if (mem3[12'o0010] !== 12'o0101) begin
            n_fails++;
            $display("FAIL mem3[0010]: got %o expected 0101", mem3[12'o0010]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem1[i] = '0;
            mem3[i] = '0;
        end
        mem1[12'o0030] = 12'o3000;
        mem1[12'o0010] = 12'o7777;
        mem1[12'o0017] = 12'o0100;
        mem1[12'o0020] = 12'o1234;
        mem1[12'o0007] = 12'o2222;
        mem1[12'o0210] = 12'o4444;
        mem3[12'o0030] = 12'o3000;
        mem3[12'o0010] = 12'o0100;
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        test_direct;
        test_indirect;
        test_autoindex;
        test_non_mri;
        test_start_held;
        test_reset_mid;
        test_latency3;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
